// File: rtl/mac_audio_resampler.sv
// Linear interpolator from the per-scanline sound latch to a fixed-rate 16-bit stream.
// Define MAC_AUDIO_DC_BLOCK_EN to add a DC-blocking high-pass stage (one extra clock of latency).
module mac_audio_resampler #(
  parameter int unsigned CLK_HZ    = 32500000,
  parameter int unsigned OUT_HZ    = 48000,
  parameter int unsigned PHASE_INC = 45
) (
  input  logic               clk32,
  input  logic               reset,
  input  logic signed [10:0] sample_in,
  input  logic               sample_strobe,
  input  logic               mute,
  output logic signed [15:0] audio_out,
  output logic               audio_valid
);

  logic signed [10:0] prev_q, prev_d, cur_q, cur_d;
  logic [15:0]        phase_q, phase_d;
  logic [16:0]        phase_sum;
  logic [31:0]        acc_q, acc_d, acc_sum;
  logic               tick;
  logic [7:0]         frac;
  logic signed [11:0] diff;
  logic signed [20:0] diff_ext, frac_ext, prod;
  logic               s1_valid_q;
  logic signed [10:0] s1_prev_q;
  logic signed [20:0] s1_prod_q;
  logic signed [12:0] interp_wide;
  logic signed [15:0] pre;

  // Phase saturates instead of wrapping so a stalled input settles on cur.
  always_comb begin
    prev_d    = prev_q;
    cur_d     = cur_q;
    phase_sum = {1'b0, phase_q} + 17'(PHASE_INC);
    phase_d   = phase_sum[16] ? 16'hFFFF : phase_sum[15:0];
    if (sample_strobe) begin
      prev_d  = cur_q;
      cur_d   = mute ? 11'sd0 : sample_in;
      phase_d = '0;
    end
  end

  always_comb begin
    acc_sum = acc_q + OUT_HZ;
    tick    = (acc_sum >= CLK_HZ);
    acc_d   = tick ? (acc_sum - CLK_HZ) : acc_sum;
  end

  assign frac = phase_q[15:8];

  always_comb begin
    diff     = {cur_q[10], cur_q} - {prev_q[10], prev_q};
    diff_ext = {{9{diff[11]}}, diff};
    frac_ext = {13'd0, frac};
    prod     = diff_ext * frac_ext;
  end

  always_comb begin
    interp_wide = {{2{s1_prev_q[10]}}, s1_prev_q} + s1_prod_q[20:8];
    pre         = {interp_wide[10:0], 5'd0};
  end

  // The tick cycle samples the registered prev/cur/frac, so a same-cycle strobe lands on the next tick.
  always_ff @(posedge clk32) begin
    if (reset) begin
      prev_q     <= '0;
      cur_q      <= '0;
      phase_q    <= '0;
      acc_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_prev_q  <= '0;
      s1_prod_q  <= '0;
    end else begin
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      s1_valid_q <= tick;
      if (tick) begin
        s1_prev_q <= prev_q;
        s1_prod_q <= prod;
      end
    end
  end

  // audio_valid is a one-cycle qualifier for audio_out; there is no backpressure.
`ifdef MAC_AUDIO_DC_BLOCK_EN
  logic signed [15:0] x_q, xp_q, y_out;
  logic signed [17:0] y_q, y_d;
  logic signed [19:0] y_sum;
  logic               s2_valid_q;
  logic signed [15:0] out_q;
  logic               valid_q;

  always_comb begin
    y_sum = {{4{x_q[15]}}, x_q} - {{4{xp_q[15]}}, xp_q}
          + {{2{y_q[17]}}, y_q} - {{12{y_q[17]}}, y_q[17:10]};
    if (y_sum > 20'sd131071)       y_d = 18'sd131071;
    else if (y_sum < -20'sd131072) y_d = -18'sd131072;
    else                           y_d = y_sum[17:0];
    if (y_d > 18'sd32767)          y_out = 16'sh7FFF;
    else if (y_d < -18'sd32768)    y_out = 16'sh8000;
    else                           y_out = y_d[15:0];
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      x_q        <= '0;
      xp_q       <= '0;
      y_q        <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      valid_q    <= s2_valid_q;
      if (s1_valid_q) x_q <= pre;
      if (s2_valid_q) begin
        xp_q  <= x_q;
        y_q   <= y_d;
        out_q <= y_out;
      end
    end
  end
`else
  logic signed [15:0] out_q;
  logic               valid_q;

  always_ff @(posedge clk32) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) out_q <= pre;
    end
  end
`endif

  assign audio_out   = out_q;
  assign audio_valid = valid_q;

endmodule

// File: tb/tb_mac_audio_resampler.sv
// Bench for mac_audio_resampler: fixed vectors, hand sequences and random strobes checked
// against an arithmetic reference model. Honours MAC_AUDIO_DC_BLOCK_EN.
`timescale 1ns/1ps
module tb_mac_audio_resampler;
  localparam int CLK_HZ    = 32500000;
  localparam int OUT_HZ    = 48000;
  localparam int PHASE_INC = 45;
`ifdef MAC_AUDIO_DC_BLOCK_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [10:0] p;
    logic [10:0] c;
    int          k;
    logic [15:0] exp;
  } vec_t;

  logic        clk32 = 1'b0;
  logic        reset;
  logic [10:0] sample_in;
  logic        sample_strobe;
  logic        mute;
  logic [15:0] audio_out;
  logic        audio_valid;

  int total = 0;
  int bad   = 0;
  longint n;
  longint m_last;
  int m_prev, m_cur;
`ifdef MAC_AUDIO_DC_BLOCK_EN
  int m_y, m_xp;
`endif
  logic [15:0] exp_q[$];
  longint      due_q[$];
  vec_t        vecs[7];

  mac_audio_resampler #(.CLK_HZ(CLK_HZ), .OUT_HZ(OUT_HZ), .PHASE_INC(PHASE_INC)) dut (
    .clk32(clk32), .reset(reset), .sample_in(sample_in), .sample_strobe(sample_strobe),
    .mute(mute), .audio_out(audio_out), .audio_valid(audio_valid)
  );

  always #15 clk32 = ~clk32;

  function automatic longint ticks_before(input longint m);
    return (m * longint'(OUT_HZ)) / longint'(CLK_HZ);
  endfunction

  function automatic bit tick_at(input longint m);
    return ticks_before(m + 1) != ticks_before(m);
  endfunction

  function automatic longint next_tick(input longint from);
    longint m = from;
    while (!tick_at(m)) m++;
    return m;
  endfunction

  function automatic logic [15:0] model_sample(input int p, input int c, input int fr);
    int ip, x;
    ip = p + (((c - p) * fr) >>> 8);
    x  = ip * 32;
`ifdef MAC_AUDIO_DC_BLOCK_EN
    begin
      int yn;
      yn = x - m_xp + m_y - (m_y >>> 10);
      if (yn > 131071) yn = 131071;
      if (yn < -131072) yn = -131072;
      m_y  = yn;
      m_xp = x;
      if (yn > 32767) yn = 32767;
      if (yn < -32768) yn = -32768;
      return 16'(yn);
    end
`else
    return 16'(x);
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at n=%0d", name, act, exp, n);
    end
  endtask

  task automatic check_fixed(input string name, input logic [15:0] exp);
`ifndef MAC_AUDIO_DC_BLOCK_EN
    check({name, "_valid"}, {15'd0, audio_valid}, 16'd1);
    check(name, audio_out, exp);
`endif
  endtask

  // One clock: model the cycle being driven, advance, then score the outputs.
  task automatic step();
    longint ph;
    int fr;
    if (reset) begin
      exp_q.delete();
      due_q.delete();
      m_prev = 0;
      m_cur  = 0;
`ifdef MAC_AUDIO_DC_BLOCK_EN
      m_y  = 0;
      m_xp = 0;
`endif
    end else begin
      if (tick_at(n)) begin
        ph = longint'(PHASE_INC) * (n - m_last - 1);
        if (ph > 65535) ph = 65535;
        fr = int'(ph >>> 8);
        exp_q.push_back(model_sample(m_prev, m_cur, fr));
        due_q.push_back(n + LAT);
      end
      if (sample_strobe) begin
        m_prev = m_cur;
        m_cur  = mute ? 0 : int'($signed(sample_in));
        m_last = n;
      end
    end
    @(posedge clk32);
    #1;
    if (reset) begin
      n = 0;
      m_last = -1;
    end else n++;
    if (due_q.size() > 0 && due_q[0] == n) begin
      void'(due_q.pop_front());
      check("valid", {15'd0, audio_valid}, 16'd1);
      check("sample", audio_out, exp_q.pop_front());
    end else begin
      check("no_valid", {15'd0, audio_valid}, 16'd0);
    end
  endtask

  task automatic idle_until(input longint x);
    while (n < x) step();
  endtask

  task automatic strobe(input logic [10:0] v);
    sample_in     = v;
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    longint t;
    t = next_tick(n + v.k + 20);
    idle_until(t - v.k - 11);
    strobe(v.p);
    idle_until(t - v.k - 1);
    strobe(v.c);
    idle_until(t + LAT);
    check_fixed($sformatf("vec%0d", idx), v.exp);
  endtask

  initial begin
    longint t, a;
    int cnt, gap;
    reset = 1'b1;
    sample_in = '0;
    sample_strobe = 1'b0;
    mute = 1'b0;
    n = 0;
    m_last = -1;
    vecs[0] = '{11'h000, 11'h100, 729,  16'h1000};
    vecs[1] = '{11'h000, 11'h700, 1451, 16'hE020};
    vecs[2] = '{11'h010, 11'h010, 1460, 16'h0200};
    vecs[3] = '{11'h100, 11'h000, 0,    16'h2000};
    vecs[4] = '{11'h3FF, 11'h400, 1455, 16'h80E0};
    vecs[5] = '{11'h400, 11'h3FF, 365,  16'hBFE0};
    vecs[6] = '{11'h050, 11'h7F0, 6,    16'h09E0};

    repeat (3) step();
    reset = 1'b0;
    check("reset_out", audio_out, 16'h0000);
    check("reset_valid", {15'd0, audio_valid}, 16'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Strobe lands on the tick cycle: that output still uses the old pair.
    t = next_tick(n + 3020);
    idle_until(t - 3000);
    strobe(11'h010);
    idle_until(t - 1500);
    strobe(11'h020);
    idle_until(t);
    strobe(11'h7FF);
    idle_until(t + LAT);
    check_fixed("strobe_on_tick", 16'h03E0);

    // Strobes stop: output holds with frac saturated, and the pulse rate is exact.
    strobe(11'h100);
    idle_until(n + 30);
    strobe(11'h123);
    a = n + 1500;
    idle_until(a);
    cnt = 0;
    repeat (8000) begin
      step();
      if (audio_valid) begin
        cnt++;
`ifndef MAC_AUDIO_DC_BLOCK_EN
        check("hold", audio_out, 16'h2440);
`endif
      end
    end
    check("rate", 16'(cnt), 16'(ticks_before(a + 8000 - LAT + 1) - ticks_before(a + 1 - LAT)));

    // Mute held across two strobes drives the target to zero.
    mute = 1'b1;
    strobe(11'h155);
    idle_until(n + 1500);
    strobe(11'h2AA);
    t = next_tick(n + 2);
    idle_until(t + LAT);
    check_fixed("mute", 16'h0000);
    mute = 1'b0;

    for (int i = 0; i < 20; i++) begin
      gap  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 60)) : int'($urandom_range(1400, 1520));
      mute = ($urandom_range(0, 7) == 0);
      idle_until(n + gap);
      strobe(11'($urandom_range(0, 2047)));
    end
    mute = 1'b0;

    // Reset while a tick is inside the pipeline.
    t = next_tick(n + 5);
    idle_until(t + 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_out", audio_out, 16'h0000);
    check("rst_mid_valid", {15'd0, audio_valid}, 16'd0);
    repeat (10) step();
    check("rst_mid_hold", audio_out, 16'h0000);
    check("drain", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
